// File: rtl/fp_arb_pkg.sv
// fp_arb_pkg: arbiter state encoding and single-precision constants.
package fp_arb_pkg;
    typedef enum logic [2:0] {IDLE, SEND_A, SEND_B, WAIT_Z, DELIVER} state_t;
    localparam int FP_W = 32;
    localparam logic [FP_W-1:0] ONE   = 32'h3F800000;
    localparam logic [FP_W-1:0] TWO   = 32'h40000000;
    localparam logic [FP_W-1:0] THREE = 32'h40400000;
endpackage

// File: rtl/fp_adder_arbiter_if.sv
// fp_adder_arbiter_if: requester-side and adder-side stb/ack buses of the arbiter.
interface fp_adder_arbiter_if #(parameter int N = 4, parameter int W = 32);
    logic [N*W-1:0] req_a, req_b;
    logic [N-1:0]   req_stb, req_ack, resp_stb, resp_ack;
    logic [W-1:0]   resp_z, add_a, add_b, add_z;
    logic           add_a_stb, add_a_ack, add_b_stb, add_b_ack, add_z_stb, add_z_ack;
    modport master (
        input  req_a, req_b, req_stb, resp_ack, add_a_ack, add_b_ack, add_z, add_z_stb,
        output req_ack, resp_z, resp_stb, add_a, add_a_stb, add_b, add_b_stb, add_z_ack
    );
    modport slave (
        output req_a, req_b, req_stb, resp_ack, add_a_ack, add_b_ack, add_z, add_z_stb,
        input  req_ack, resp_z, resp_stb, add_a, add_a_stb, add_b, add_b_stb, add_z_ack
    );
endinterface

// File: rtl/fp_adder_arbiter_rr_picker.sv
// rr_picker: first set request bit searching upward from last_grant+1, wrapping.
module rr_picker #(
    parameter int N  = 4,
    parameter int GW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [GW-1:0] last_i,
    output logic [GW-1:0] grant_o,
    output logic          any_o
);
    // Walk from the farthest candidate down so the nearest one is written last.
    always_comb begin
        grant_o = '0;
        any_o   = |req_i;
        for (int i = N; i >= 1; i--)
            if (req_i[(int'(last_i) + i) % N]) grant_o = GW'((int'(last_i) + i) % N);
    end
endmodule

// File: rtl/fp_adder_arbiter.sv
// fp_adder_arbiter: round-robin sharing of one stb/ack floating-point adder among N requesters.
module fp_adder_arbiter
    import fp_arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int W     = FP_W,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    fp_adder_arbiter_if.master   bus,
    output logic                 busy,
    output logic [$clog2(N)-1:0] grant_id,
    output logic [CNT_W-1:0]     op_count
);
    localparam int GW = $clog2(N);
    state_t         state_q, state_d;
    logic [GW-1:0]  last_q, last_d, grant_q, grant_d, pick;
    logic           any_req;
    logic [W-1:0]   add_a_q, add_a_d, add_b_q, add_b_d, resp_z_q, resp_z_d;
    logic           a_stb_q, a_stb_d, b_stb_q, b_stb_d, z_ack_q, z_ack_d, busy_q, busy_d;
    logic [N-1:0]   req_ack_q, req_ack_d, resp_stb_q, resp_stb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    rr_picker #(.N(N), .GW(GW)) u_pick (
        .req_i   (bus.req_stb),
        .last_i  (last_q),
        .grant_o (pick),
        .any_o   (any_req)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            last_q     <= GW'(N - 1);
            grant_q    <= '0;
            add_a_q    <= '0;
            add_b_q    <= '0;
            resp_z_q   <= '0;
            a_stb_q    <= 1'b0;
            b_stb_q    <= 1'b0;
            z_ack_q    <= 1'b0;
            busy_q     <= 1'b0;
            req_ack_q  <= '0;
            resp_stb_q <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            grant_q    <= grant_d;
            add_a_q    <= add_a_d;
            add_b_q    <= add_b_d;
            resp_z_q   <= resp_z_d;
            a_stb_q    <= a_stb_d;
            b_stb_q    <= b_stb_d;
            z_ack_q    <= z_ack_d;
            busy_q     <= busy_d;
            req_ack_q  <= req_ack_d;
            resp_stb_q <= resp_stb_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        grant_d    = grant_q;
        add_a_d    = add_a_q;
        add_b_d    = add_b_q;
        resp_z_d   = resp_z_q;
        a_stb_d    = a_stb_q;
        b_stb_d    = b_stb_q;
        z_ack_d    = z_ack_q;
        busy_d     = busy_q;
        req_ack_d  = '0;
        resp_stb_d = resp_stb_q;
        cnt_d      = cnt_q;
        case (state_q)
            IDLE: if (any_req) begin
                add_a_d   = bus.req_a[int'(pick)*W +: W];
                add_b_d   = bus.req_b[int'(pick)*W +: W];
                grant_d   = pick;
                busy_d    = 1'b1;
                req_ack_d = N'(1) << pick;
                a_stb_d   = 1'b1;
                state_d   = SEND_A;
            end
            SEND_A: if (a_stb_q && bus.add_a_ack) begin
                a_stb_d = 1'b0;
                b_stb_d = 1'b1;
                state_d = SEND_B;
            end
            SEND_B: if (b_stb_q && bus.add_b_ack) begin
                b_stb_d = 1'b0;
                z_ack_d = 1'b1;
                state_d = WAIT_Z;
            end
            WAIT_Z: if (z_ack_q && bus.add_z_stb) begin
                resp_z_d   = bus.add_z;
                z_ack_d    = 1'b0;
                resp_stb_d = N'(1) << grant_q;
                state_d    = DELIVER;
            end
            DELIVER: if (resp_stb_q[grant_q] && bus.resp_ack[grant_q]) begin
                resp_stb_d = '0;
                cnt_d      = cnt_q + CNT_W'(1);
                last_d     = grant_q;
                busy_d     = 1'b0;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.req_ack   = req_ack_q;
    assign bus.resp_stb  = resp_stb_q;
    assign bus.resp_z    = resp_z_q;
    assign bus.add_a     = add_a_q;
    assign bus.add_b     = add_b_q;
    assign bus.add_a_stb = a_stb_q;
    assign bus.add_b_stb = b_stb_q;
    assign bus.add_z_ack = z_ack_q;
    assign busy          = busy_q;
    assign grant_id      = grant_q;
    assign op_count      = cnt_q;
endmodule

// File: tb/tb_fp_adder_arbiter.sv
// tb_fp_adder_arbiter: directed bench with a table-driven stub adder and auto-responding requesters.
module tb_fp_adder_arbiter;
    import fp_arb_pkg::*;
    localparam logic [31:0] FOUR = 32'h40800000, ONE_HALF = 32'h3FC00000, TWO_HALF = 32'h40200000;

    logic        clk, rst, busy;
    logic [1:0]  grant_id;
    logic [15:0] op_count;
    fp_adder_arbiter_if #(.N(4), .W(32)) bus ();

    fp_adder_arbiter #(.N(4), .W(32), .CNT_W(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .busy     (busy),
        .grant_id (grant_id),
        .op_count (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int a_dly, b_dly, z_lat;
    int a_cnt, b_cnt, z_cnt;
    logic z_run;
    logic [31:0] ra;

    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {ONE, TWO}:      return THREE;
            {ONE, ONE}:      return TWO;
            {TWO, TWO}:      return FOUR;
            {ONE_HALF, ONE}: return TWO_HALF;
            default:         return 32'hDEADBEEF;
        endcase
    endfunction

    // Stub adder: acks each operand after a programmable delay, result after z_lat cycles.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.add_a_ack <= 1'b0;
            bus.add_b_ack <= 1'b0;
            bus.add_z_stb <= 1'b0;
            bus.add_z     <= '0;
            a_cnt <= 0; b_cnt <= 0; z_cnt <= 0; z_run <= 1'b0; ra <= '0;
        end else begin
            if (bus.add_a_stb && bus.add_a_ack) begin
                ra <= bus.add_a; bus.add_a_ack <= 1'b0; a_cnt <= 0;
            end else if (bus.add_a_stb) begin
                if (a_cnt >= a_dly) bus.add_a_ack <= 1'b1; else a_cnt <= a_cnt + 1;
            end
            if (bus.add_b_stb && bus.add_b_ack) begin
                bus.add_b_ack <= 1'b0; b_cnt <= 0; z_run <= 1'b1; z_cnt <= 0;
                bus.add_z <= fadd(ra, bus.add_b);
            end else if (bus.add_b_stb) begin
                if (b_cnt >= b_dly) bus.add_b_ack <= 1'b1; else b_cnt <= b_cnt + 1;
            end
            if (z_run) begin
                if (z_cnt >= z_lat) begin bus.add_z_stb <= 1'b1; z_run <= 1'b0; end
                else z_cnt <= z_cnt + 1;
            end
            if (bus.add_z_stb && bus.add_z_ack) bus.add_z_stb <= 1'b0;
        end
    end

    int rem[4], rdly[4], hcnt[4], ackn[4];
    int order[$];
    logic [31:0] res[$];
    logic [3:0] prev_ack;
    int onehot_bad = 0, pulse_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // One cycle of requester behaviour, sampled and driven on the falling edge.
    task automatic step();
        @(negedge clk);
        if (!$onehot0(bus.resp_stb)) onehot_bad++;
        if (|(bus.req_ack & prev_ack)) pulse_bad++;
        prev_ack = bus.req_ack;
        for (int i = 0; i < 4; i++) begin
            if (bus.req_ack[i]) begin
                ackn[i]++;
                if (rem[i] > 0) rem[i]--;
            end
            bus.req_stb[i] = rem[i] > 0;
            if (bus.resp_stb[i]) begin
                if (hcnt[i] < rdly[i]) begin
                    hcnt[i]++; bus.resp_ack[i] = 1'b0;
                end else if (!bus.resp_ack[i]) begin
                    bus.resp_ack[i] = 1'b1; order.push_back(i); res.push_back(bus.resp_z);
                end
            end else begin
                bus.resp_ack[i] = 1'b0; hcnt[i] = 0;
            end
        end
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < 4; i++) begin rem[i] = 0; rdly[i] = 0; hcnt[i] = 0; ackn[i] = 0; end
        bus.req_stb = '0; bus.resp_ack = '0; prev_ack = '0;
        order.delete(); res.delete();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_reqs();
        repeat (2) step();
        rst = 1'b1;
    endtask

    task automatic wait_ops(input string tag, input int n);
        int k = 0;
        while (op_count != 16'(n) && k < 400) begin step(); k++; end
        chk(tag, 32'(k < 400), 1);
    endtask

    int k, held, bad;
    logic [31:0] packed_order;

    initial begin
        a_dly = 0; b_dly = 0; z_lat = 2;
        bus.req_a = {ONE_HALF, TWO, ONE, ONE};
        bus.req_b = {ONE, TWO, ONE, TWO};
        do_reset();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_grant", 32'(grant_id), 0);
        chk("rst_count", 32'(op_count), 0);
        chk("rst_outs", {bus.req_ack, bus.resp_stb, bus.add_a_stb, bus.add_b_stb, bus.add_z_ack}, 0);
        chk("rst_resp_z", bus.resp_z, 0);

        // Single request from requester 0: 1.0 + 2.0
        rem[0] = 1;
        wait_ops("t1_tmo", 1);
        chk("t1_order", 32'(order[0]), 0);
        chk("t1_sum", res[0], THREE);
        chk("t1_ackn", 32'(ackn[0]), 1);
        chk("t1_busy", 32'(busy), 0);

        // Requesters 1 and 2 together after reset
        do_reset();
        rem[1] = 1; rem[2] = 1;
        wait_ops("t2_tmo", 2);
        chk("t2_order", {16'(order[0]), 16'(order[1])}, {16'd1, 16'd2});
        chk("t2_sum1", res[0], TWO);
        chk("t2_sum2", res[1], FOUR);
        chk("t2_grant", 32'(grant_id), 2);

        // All four requesting continuously for two rounds
        do_reset();
        for (int i = 0; i < 4; i++) rem[i] = 2;
        wait_ops("t3_tmo", 8);
        packed_order = '0;
        foreach (order[i]) packed_order = (packed_order << 4) | 32'(order[i]);
        chk("t3_order", packed_order, 32'h01230123);
        chk("t3_count", 32'(op_count), 8);
        chk("t3_sum3", res[3], TWO_HALF);

        // resp_ack[0] held off five cycles while requester 1 waits
        rdly[0] = 5; rem[0] = 1; rem[1] = 1;
        k = 0;
        while (!bus.resp_stb[0] && k < 100) begin step(); k++; end
        held = 0; bad = 0;
        while (bus.resp_stb[0] && !bus.resp_ack[0] && held < 50) begin
            held++;
            if (bus.resp_z !== THREE || bus.req_ack !== 4'b0 || !busy) bad++;
            step();
        end
        chk("t4_hold", 32'(held), 5);
        chk("t4_stable", 32'(bad), 0);
        wait_ops("t4_tmo", 10);
        chk("t4_order", {16'(order[8]), 16'(order[9])}, {16'd0, 16'd1});
        chk("t4_sum", res[9], TWO);

        // add_a_ack stalled: add_a_stb and add_a held, add_b_stb held off
        a_dly = 3; rem[2] = 1;
        k = 0;
        while (!bus.add_a_stb && k < 50) begin step(); k++; end
        held = 0; bad = 0;
        while (bus.add_a_stb && held < 50) begin
            held++;
            if (bus.add_b_stb || bus.add_a !== TWO) bad++;
            step();
        end
        chk("t5_hold", 32'(held), 5);
        chk("t5_stable", 32'(bad), 0);
        chk("t5_b_stb", 32'(bus.add_b_stb), 1);
        wait_ops("t5_tmo", 11);
        a_dly = 0;
        chk("t5_sum", res[10], FOUR);

        // Asynchronous reset while waiting on the adder result
        z_lat = 20; rem[3] = 1;
        k = 0;
        while (!bus.add_z_ack && k < 50) begin step(); k++; end
        chk("t6_in_wait", 32'(bus.add_z_ack), 1);
        #2 rst = 1'b0;
        #1;
        chk("t6_busy", 32'(busy), 0);
        chk("t6_count", 32'(op_count), 0);
        chk("t6_grant", 32'(grant_id), 0);
        chk("t6_outs", {bus.req_ack, bus.resp_stb, bus.add_a_stb, bus.add_b_stb, bus.add_z_ack}, 0);
        chk("t6_data", bus.add_a | bus.add_b | bus.resp_z, 0);
        clear_reqs();
        repeat (2) step();
        rst = 1'b1;
        z_lat = 2; rem[2] = 1;
        wait_ops("t6_tmo", 1);
        chk("t6_n", 32'(order.size()), 1);
        chk("t6_who", 32'(order[0]), 2);
        chk("t6_sum", res[0], FOUR);

        chk("onehot_resp", 32'(onehot_bad), 0);
        chk("ack_pulse", 32'(pulse_bad), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
